stepper_ramp_ctrl: RTL and testbench
====================================

# stepper_ramp_ctrl

Stepper motor move sequencer in the motor subsystem. Accepts move commands (step count, direction) over a valid/ready handshake and produces coil phase patterns with a trapezoidal speed profile: accelerate, cruise, decelerate. Step timing is a clock-cycle period counter in the `clk` domain, replacing derived divider clocks as the step-rate source. Downstream the `phase` output drives the H-bridge pins directly.

## Interface
- `CNT_W`, 14: width of the period counter and period register.
- `START_PERIOD`, 100: step interval in clk cycles at standstill; also the deceleration end value.
- `MIN_PERIOD`, 40: cruise step interval; requires MIN_PERIOD ≤ START_PERIOD.
- `ACCEL_STEP`, 20: period change per step during ramps.
- `clk`  in  1  system clock.
- `n_rst`  in  1  synchronous, active-low reset.
- `cmd_valid`  in  1  move command present.
- `cmd_ready`  out  1  high in IDLE only.
- `cmd_dir`  in  1  1 = forward (phase index +1), 0 = reverse (−1).
- `cmd_steps`  in  16  number of steps to move.
- `stop_req`  in  1  single-cycle request for a controlled stop.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse when a move finishes.
- `step_pulse`  out  1  one-cycle pulse per step.
- `phase`  out  4  coil drive pattern.

## Operation
- States: IDLE, ACCEL, CRUISE, DECEL.
- Accept when `cmd_valid && cmd_ready`:
  - latch `dir` and `remaining = cmd_steps`;
  - set `period = START_PERIOD`, `timer = 0`, `ramp = 0`;
  - go to ACCEL.
- `cmd_steps == 0`: accepted, no step issued, `done` pulses the next cycle, state stays IDLE.
- In non-IDLE states `timer` increments every cycle. When `timer == period-1` a step occurs:
  - `timer` clears;
  - the phase index advances by ±1 modulo the sequence length;
  - `remaining` decrements (call the new value `rem`).
- Step update, first stage: in ACCEL, `ramp_a = ramp+1` and `period_a = max(period−ACCEL_STEP, MIN_PERIOD)`; otherwise `ramp_a = ramp` and `period_a = period`.
- Step update, next state (priority order):
  - `rem == 0` → IDLE and pulse `done`.
  - else `rem ≤ ramp_a` → DECEL, with `period = min(period_a+ACCEL_STEP, START_PERIOD)` and `ramp = ramp_a−1` (saturating at 0).
  - else ACCEL with `period_a == MIN_PERIOD` → CRUISE.
  - else stay in the current state and load `period_a`/`ramp_a`.
- Period arithmetic is CNT_W+1 bits internally and saturating; no wrap.
- `stop_req` in ACCEL/CRUISE sets `remaining = min(remaining, ramp+1)` and goes to DECEL, leaving `period` unchanged. At least one further step is always issued.
- `stop_req` in IDLE/DECEL is ignored.
- If a step occurs in the same cycle as `stop_req`, the step update is applied first and the stop then acts on the result. If that result is IDLE, the stop is ignored.
- `cmd_valid` while busy is not accepted; the upstream holds it.
- `phase` holds its last value in IDLE (holding torque).

## Timing
- Reset values: state IDLE, `cmd_ready = 1`, `busy = 0`, `done = 0`, `step_pulse = 0`, phase index 0, all counters 0.
- Reset mid-move abandons the move immediately; `done` is not pulsed.
- All outputs are registered.
- `step_pulse` and the new `phase` appear in the same cycle, one cycle after `timer == period-1`.
- The first step pulse occurs START_PERIOD cycles after the accept edge.
- `done` is asserted in the same cycle as the final `step_pulse`; `cmd_ready` rises in the same cycle.

## Configuration
- `STEPPER_HALFSTEP_EN` defined: 8-entry half-step sequence 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001; index 0 = 1000.
- `STEPPER_HALFSTEP_EN` undefined: 4-entry full-step two-phase-on sequence 1100, 0110, 0011, 1001; index 0 = 1100.

## Structure
- Package `motor_pkg`:
  - state enum `stepper_state_t`;
  - phase lookup tables for both modes;
  - `STEPPER_SEQ_LEN` constant.
- Sub-module `step_timer`: period counter. Inputs are `period`, `run` and `clr`; output is the `tick` pulse.

## Test plan
- Reset, then a 10-step forward move (defaults) → step intervals exactly 100, 80, 60, 40, 40, 40, 40, 60, 80, 100; `done` with the 10th pulse; phase returns to 0011 after 10 full steps (index 2).
- 4-step reverse move → intervals 100, 80, 80, 100; phase sequence from 1100: 1001, 0011, 0110, 1100.
- `cmd_steps = 0` → no `step_pulse`; `done` one cycle after accept; `busy` never high.
- `stop_req` during cruise of a 1000-step move with ramp = 3 → exactly 4 more steps at intervals 40, 60, 80, 100, then `done`; `cmd_valid` held during the move is not accepted until `cmd_ready`.
- `n_rst` low mid-acceleration → next cycle state IDLE, `phase = 1100`, no `done`; a new command is then accepted normally.
- With `STEPPER_HALFSTEP_EN`: 8 forward steps → phase returns to 1000 after visiting all 8 patterns in order.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared types and coil phase tables for the stepper move sequencer.
// STEPPER_HALFSTEP_EN selects the 8-entry half-step table; otherwise full-step two-phase-on.
package motor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCEL  = 2'd1,
      ST_CRUISE = 2'd2,
      ST_DECEL  = 2'd3
   } stepper_state_t;

   localparam logic [3:0] HALF_SEQ [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                           4'b0010, 4'b0011, 4'b0001, 4'b1001};
   localparam logic [3:0] FULL_SEQ [4] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};

`ifdef STEPPER_HALFSTEP_EN
   localparam int STEPPER_SEQ_LEN = 8;
   localparam bit HALFSTEP        = 1'b1;
`else
   localparam int STEPPER_SEQ_LEN = 4;
   localparam bit HALFSTEP        = 1'b0;
`endif

   localparam logic [2:0] SEQ_MASK = 3'(STEPPER_SEQ_LEN - 1);

   function automatic logic [3:0] phase_lut(input logic [2:0] idx);
      return HALFSTEP ? HALF_SEQ[idx] : FULL_SEQ[idx[1:0]];
   endfunction

   // Sequence lengths are powers of two, so masking gives the modulo wrap.
   function automatic logic [2:0] idx_step(input logic [2:0] idx, input logic fwd);
      logic [2:0] nxt;
      nxt = fwd ? idx + 3'd1 : idx - 3'd1;
      return nxt & SEQ_MASK;
   endfunction

endpackage

// File: rtl/step_timer.sv
// Step period counter: counts clk cycles while running and pulses tick on the
// last cycle of each period, restarting from zero.
module step_timer #(
   parameter int CNT_W = 14
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic [CNT_W-1:0] period,
   input  logic             run,
   input  logic             clr,
   output logic             tick
);

   logic [CNT_W-1:0] timer;
   logic [CNT_W:0]   timer_inc;

   assign timer_inc = {1'b0, timer} + {{CNT_W{1'b0}}, 1'b1};
   // >= rather than == so a period shorter than the current count still ends promptly
   assign tick      = run && (timer_inc >= {1'b0, period});

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         timer <= '0;
      end else if (clr || !run || tick) begin
         timer <= '0;
      end else begin
         timer <= timer_inc[CNT_W-1:0];
      end
   end

endmodule

// File: rtl/stepper_ramp_ctrl.sv
// Stepper move sequencer with trapezoidal step-rate profile.
// Phase table chosen by STEPPER_HALFSTEP_EN (see motor_pkg).
//
//   state     | meaning
//   ----------+--------------------------------------------------
//   ST_IDLE   | waiting for a command, phase held for torque
//   ST_ACCEL  | period shrinks by ACCEL_STEP per step
//   ST_CRUISE | period held at MIN_PERIOD
//   ST_DECEL  | period grows by ACCEL_STEP per step to standstill
module stepper_ramp_ctrl
   import motor_pkg::*;
#(
   parameter int CNT_W        = 14,
   parameter int START_PERIOD = 100,
   parameter int MIN_PERIOD   = 40,
   parameter int ACCEL_STEP   = 20
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_dir,
   input  logic [15:0] cmd_steps,
   input  logic        stop_req,
   output logic        busy,
   output logic        done,
   output logic        step_pulse,
   output logic [3:0]  phase
);

   localparam int PW = CNT_W + 1;
   localparam logic [PW-1:0] START_W = PW'(START_PERIOD);
   localparam logic [PW-1:0] MIN_W   = PW'(MIN_PERIOD);
   localparam logic [PW-1:0] ACC_W   = PW'(ACCEL_STEP);

   stepper_state_t   state, state_n;
   logic             dir_q, dir_n;
   logic [15:0]      remaining, rem_n, rem_dec;
   logic [15:0]      ramp, ramp_n, ramp_a, ramp_lim;
   logic [CNT_W-1:0] period, period_n;
   logic [PW-1:0]    period_w, period_a, period_up;
   logic [2:0]       idx, idx_n;
   logic             done_n, step_n;
   logic             timer_clr, tick;

   step_timer #(.CNT_W(CNT_W)) u_step_timer (
      .clk    (clk),
      .n_rst  (n_rst),
      .period (period),
      .run    (state != ST_IDLE),
      .clr    (timer_clr),
      .tick   (tick)
   );

   always_comb begin
      state_n   = state;
      dir_n     = dir_q;
      rem_n     = remaining;
      period_n  = period;
      ramp_n    = ramp;
      idx_n     = idx;
      done_n    = 1'b0;
      step_n    = 1'b0;
      timer_clr = 1'b0;
      ramp_lim  = '0;

      rem_dec  = remaining - 16'd1;
      period_w = {1'b0, period};
      if (state == ST_ACCEL) begin
         ramp_a   = ramp + 16'd1;
         period_a = (period_w >= MIN_W + ACC_W) ? period_w - ACC_W : MIN_W;
      end else begin
         ramp_a   = ramp;
         period_a = period_w;
      end
      period_up = (period_a + ACC_W > START_W) ? START_W : period_a + ACC_W;

      case (state)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               dir_n     = cmd_dir;
               rem_n     = cmd_steps;
               period_n  = CNT_W'(START_W);
               ramp_n    = '0;
               timer_clr = 1'b1;
               if (cmd_steps == 16'd0) begin
                  done_n = 1'b1;
               end else begin
                  state_n = ST_ACCEL;
               end
            end
         end
         default: begin
            if (tick) begin
               step_n = 1'b1;
               idx_n  = idx_step(idx, dir_q);
               rem_n  = rem_dec;
               if (rem_dec == 16'd0) begin
                  state_n = ST_IDLE;
                  done_n  = 1'b1;
               end else if (rem_dec <= ramp_a) begin
                  state_n  = ST_DECEL;
                  period_n = CNT_W'(period_up);
                  ramp_n   = (ramp_a == 16'd0) ? 16'd0 : ramp_a - 16'd1;
               end else begin
                  if (state == ST_ACCEL && period_a == MIN_W) begin
                     state_n = ST_CRUISE;
                  end
                  period_n = CNT_W'(period_a);
                  ramp_n   = ramp_a;
               end
            end
            // Stop acts on the post-step state so it can never cancel a finished move.
            if (stop_req && (state_n == ST_ACCEL || state_n == ST_CRUISE)) begin
               ramp_lim = ramp_n + 16'd1;
               if (rem_n > ramp_lim) begin
                  rem_n = ramp_lim;
               end
               state_n = ST_DECEL;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state      <= ST_IDLE;
         dir_q      <= 1'b0;
         remaining  <= '0;
         period     <= '0;
         ramp       <= '0;
         idx        <= '0;
         phase      <= phase_lut(3'd0);
         done       <= 1'b0;
         step_pulse <= 1'b0;
         busy       <= 1'b0;
         cmd_ready  <= 1'b1;
      end else begin
         state      <= state_n;
         dir_q      <= dir_n;
         remaining  <= rem_n;
         period     <= period_n;
         ramp       <= ramp_n;
         idx        <= idx_n;
         phase      <= phase_lut(idx_n);
         done       <= done_n;
         step_pulse <= step_n;
         busy       <= (state_n != ST_IDLE);
         cmd_ready  <= (state_n == ST_IDLE);
      end
   end

endmodule

// File: tb/tb_stepper_ramp_ctrl.sv
// Self-checking bench for stepper_ramp_ctrl: step intervals, phase order,
// done timing, stop and reset behaviour against a step-by-step profile model.
module tb_stepper_ramp_ctrl;

   localparam int START = 100;
   localparam int MINP  = 40;
   localparam int ACC   = 20;

`ifdef STEPPER_HALFSTEP_EN
   localparam int LEN = 8;
   localparam logic [3:0] SEQ_TAB [0:7] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                            4'b0010, 4'b0011, 4'b0001, 4'b1001};
`else
   localparam int LEN = 4;
   localparam logic [3:0] SEQ_TAB [0:3] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};
`endif

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_dir = 1'b1;
   logic [15:0] cmd_steps = '0;
   logic        stop_req = 1'b0;
   logic        busy, done, step_pulse;
   logic [3:0]  phase;

   int checks = 0;
   int errors = 0;
   int midx   = 0;

   int          exp_iv[$];
   int          obs_iv[$];
   logic [3:0]  obs_ph[$];
   bit          obs_timeout, obs_done_pulse, obs_ready_busy, obs_busy_any;
   int          obs_done_c, obs_wait;

   stepper_ramp_ctrl dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_dir    (cmd_dir),
      .cmd_steps  (cmd_steps),
      .stop_req   (stop_req),
      .busy       (busy),
      .done       (done),
      .step_pulse (step_pulse),
      .phase      (phase)
   );

   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference profile: list of step intervals for an n-step move, with an
   // optional stop requested once stop_at steps have been taken (-1 = none).
   function automatic void model_move(input int n, input int stop_at);
      int per, rmp, rem, st, taken, ra, pa;
      exp_iv.delete();
      per = START; rmp = 0; rem = n; st = 0; taken = 0;
      while (rem > 0) begin
         if (taken == stop_at && st != 2) begin
            if (rem > rmp + 1) rem = rmp + 1;
            st = 2;
         end
         exp_iv.push_back(per);
         rem--; taken++;
         if (st == 0) begin
            ra = rmp + 1;
            pa = (per - ACC < MINP) ? MINP : per - ACC;
         end else begin
            ra = rmp;
            pa = per;
         end
         if (rem == 0) break;
         if (rem <= ra) begin
            st  = 2;
            per = (pa + ACC > START) ? START : pa + ACC;
            rmp = (ra > 0) ? ra - 1 : 0;
         end else begin
            if (st == 0 && pa == MINP) st = 1;
            per = pa;
            rmp = ra;
         end
      end
   endfunction

   function automatic int next_idx(input int i, input bit fwd);
      return fwd ? (i + 1) % LEN : (i + LEN - 1) % LEN;
   endfunction

   // Issues one command and records what the DUT does until done (no checking here).
   task automatic do_move(input int steps, input bit dir, input int stop_at, input bit hold);
      int c, last, budget;
      bit stop_sent;
      obs_iv.delete(); obs_ph.delete();
      obs_timeout = 0; obs_done_pulse = 0; obs_ready_busy = 0; obs_busy_any = 0;
      obs_done_c = -1; obs_wait = 0; stop_sent = 0;
      budget = steps * (START + 10) + 200;
      cmd_steps = steps[15:0];
      cmd_dir   = dir;
      cmd_valid = 1'b1;
      while (cmd_ready !== 1'b1 && obs_wait < 5000) begin
         @(posedge clk); #1; obs_wait++;
      end
      if (cmd_ready !== 1'b1) begin
         obs_timeout = 1; cmd_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      if (!hold) cmd_valid = 1'b0;
      c = 0; last = 0;
      forever begin
         if (busy === 1'b1) obs_busy_any = 1;
         if (step_pulse === 1'b1) begin
            obs_iv.push_back(c - last);
            last = c;
            obs_ph.push_back(phase);
         end
         if (done === 1'b1) begin
            obs_done_c = c;
            obs_done_pulse = step_pulse;
            break;
         end
         if (cmd_ready === 1'b1) obs_ready_busy = 1;
         if (stop_at >= 0 && obs_iv.size() == stop_at && !stop_sent) begin
            stop_req = 1'b1; stop_sent = 1;
         end
         if (c >= budget) begin
            obs_timeout = 1;
            break;
         end
         @(posedge clk); #1;
         stop_req = 1'b0;
         c++;
      end
      stop_req = 1'b0;
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++; if (step_pulse !== 1'b0) begin errors++; $display("FAIL reset_step_pulse got %b want 0", step_pulse); end
      checks++; if (phase !== SEQ_TAB[0]) begin errors++; $display("FAIL reset_phase got %b want %b", phase, SEQ_TAB[0]); end
      n_rst = 1'b1;
      midx = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_fwd_ten();
      int want[10] = '{100, 80, 60, 40, 40, 40, 40, 60, 80, 100};
      do_move(10, 1'b1, -1, 1'b0);
      checks++; if (obs_timeout) begin errors++; $display("FAIL fwd10_timeout got timeout want done"); end
      checks++; if (obs_iv.size() != 10) begin errors++; $display("FAIL fwd10_count got %0d want 10", obs_iv.size()); end
      for (int i = 0; i < obs_iv.size() && i < 10; i++) begin
         checks++; if (obs_iv[i] != want[i]) begin errors++; $display("FAIL fwd10_interval[%0d] got %0d want %0d", i, obs_iv[i], want[i]); end
      end
      for (int i = 0; i < obs_ph.size(); i++) begin
         midx = next_idx(midx, 1'b1);
         checks++; if (obs_ph[i] !== SEQ_TAB[midx]) begin errors++; $display("FAIL fwd10_phase[%0d] got %b want %b", i, obs_ph[i], SEQ_TAB[midx]); end
      end
      checks++; if (phase !== SEQ_TAB[10 % LEN]) begin errors++; $display("FAIL fwd10_final_phase got %b want %b", phase, SEQ_TAB[10 % LEN]); end
      checks++; if (obs_done_pulse !== 1'b1) begin errors++; $display("FAIL fwd10_done_with_pulse got %b want 1", obs_done_pulse); end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL fwd10_ready_at_done got %b want 1", cmd_ready); end
      checks++; if (obs_ready_busy) begin errors++; $display("FAIL fwd10_ready_during_move got 1 want 0"); end
   endtask

   task automatic test_rev_four();
      int want[4] = '{100, 80, 80, 100};
      do_move(4, 1'b0, -1, 1'b0);
      checks++; if (obs_iv.size() != 4) begin errors++; $display("FAIL rev4_count got %0d want 4", obs_iv.size()); end
      for (int i = 0; i < obs_iv.size() && i < 4; i++) begin
         checks++; if (obs_iv[i] != want[i]) begin errors++; $display("FAIL rev4_interval[%0d] got %0d want %0d", i, obs_iv[i], want[i]); end
      end
      for (int i = 0; i < obs_ph.size(); i++) begin
         midx = next_idx(midx, 1'b0);
         checks++; if (obs_ph[i] !== SEQ_TAB[midx]) begin errors++; $display("FAIL rev4_phase[%0d] got %b want %b", i, obs_ph[i], SEQ_TAB[midx]); end
      end
      checks++; if (obs_done_pulse !== 1'b1) begin errors++; $display("FAIL rev4_done_with_pulse got %b want 1", obs_done_pulse); end
   endtask

   task automatic test_zero_steps();
      logic [3:0] ph0;
      ph0 = phase;
      do_move(0, 1'b1, -1, 1'b0);
      checks++; if (obs_done_c != 0) begin errors++; $display("FAIL zero_done_cycle got %0d want 0", obs_done_c); end
      checks++; if (obs_iv.size() != 0) begin errors++; $display("FAIL zero_pulses got %0d want 0", obs_iv.size()); end
      checks++; if (obs_busy_any) begin errors++; $display("FAIL zero_busy got 1 want 0"); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_after got done=%b busy=%b want 0 0", done, busy); end
      checks++; if (phase !== ph0) begin errors++; $display("FAIL zero_phase_hold got %b want %b", phase, ph0); end
   endtask

   task automatic test_stop_cruise();
      int want[4] = '{40, 60, 80, 100};
      int n;
      do_move(1000, 1'b1, 6, 1'b1);
      model_move(1000, 6);
      n = obs_iv.size();
      checks++; if (n != 10 || exp_iv.size() != 10) begin errors++; $display("FAIL stop_count got %0d want 10 (model %0d)", n, exp_iv.size()); end
      for (int i = 0; i < 4 && n >= 4; i++) begin
         checks++; if (obs_iv[n - 4 + i] != want[i]) begin errors++; $display("FAIL stop_tail[%0d] got %0d want %0d", i, obs_iv[n - 4 + i], want[i]); end
      end
      for (int i = 0; i < n && i < exp_iv.size(); i++) begin
         checks++; if (obs_iv[i] != exp_iv[i]) begin errors++; $display("FAIL stop_interval[%0d] got %0d want %0d", i, obs_iv[i], exp_iv[i]); end
      end
      for (int i = 0; i < obs_ph.size(); i++) midx = next_idx(midx, 1'b1);
      checks++; if (obs_ready_busy) begin errors++; $display("FAIL stop_held_valid_ready got 1 want 0"); end
      // Held command goes in on the edge right after done; stop it at once.
      do_move(1000, 1'b1, 0, 1'b0);
      checks++; if (obs_wait != 0) begin errors++; $display("FAIL held_accept_wait got %0d want 0", obs_wait); end
      checks++; if (obs_iv.size() != 1 || (obs_iv.size() == 1 && obs_iv[0] != START)) begin
         errors++; $display("FAIL held_stop_steps got %0d first %0d want 1 step of %0d", obs_iv.size(), (obs_iv.size() > 0) ? obs_iv[0] : -1, START);
      end
      for (int i = 0; i < obs_ph.size(); i++) midx = next_idx(midx, 1'b1);
   endtask

   task automatic test_reset_mid_move();
      bit done_seen;
      cmd_steps = 16'd50; cmd_dir = 1'b1; cmd_valid = 1'b1;
      for (int i = 0; i < 50 && cmd_ready !== 1'b1; i++) begin @(posedge clk); #1; end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (140) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b want 1", busy); end
      n_rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL midrst_state got busy=%b ready=%b want 0 1", busy, cmd_ready); end
      checks++; if (phase !== SEQ_TAB[0]) begin errors++; $display("FAIL midrst_phase got %b want %b", phase, SEQ_TAB[0]); end
      done_seen = (done === 1'b1);
      n_rst = 1'b1;
      midx = 0;
      for (int i = 0; i < 5; i++) begin @(posedge clk); #1; if (done === 1'b1) done_seen = 1; end
      checks++; if (done_seen) begin errors++; $display("FAIL midrst_done got 1 want 0"); end
      do_move(3, 1'b0, -1, 1'b0);
      model_move(3, -1);
      checks++; if (obs_iv.size() != exp_iv.size()) begin errors++; $display("FAIL midrst_new_count got %0d want %0d", obs_iv.size(), exp_iv.size()); end
      for (int i = 0; i < obs_iv.size() && i < exp_iv.size(); i++) begin
         checks++; if (obs_iv[i] != exp_iv[i]) begin errors++; $display("FAIL midrst_new_interval[%0d] got %0d want %0d", i, obs_iv[i], exp_iv[i]); end
      end
      for (int i = 0; i < obs_ph.size(); i++) begin
         midx = next_idx(midx, 1'b0);
         checks++; if (obs_ph[i] !== SEQ_TAB[midx]) begin errors++; $display("FAIL midrst_new_phase[%0d] got %b want %b", i, obs_ph[i], SEQ_TAB[midx]); end
      end
   endtask

   task automatic test_eight_steps();
      int start;
      start = midx;
      do_move(8, 1'b1, -1, 1'b0);
      checks++; if (obs_ph.size() != 8) begin errors++; $display("FAIL eight_count got %0d want 8", obs_ph.size()); end
      for (int i = 0; i < obs_ph.size(); i++) begin
         midx = next_idx(midx, 1'b1);
         checks++; if (obs_ph[i] !== SEQ_TAB[midx]) begin errors++; $display("FAIL eight_phase[%0d] got %b want %b", i, obs_ph[i], SEQ_TAB[midx]); end
      end
      checks++; if (phase !== SEQ_TAB[(start + 8) % LEN]) begin errors++; $display("FAIL eight_final got %b want %b", phase, SEQ_TAB[(start + 8) % LEN]); end
   endtask

   task automatic test_random();
      int n, stop_at;
      bit dir;
      for (int t = 0; t < 10; t++) begin
         n = int'($urandom_range(1, 25));
         dir = 1'($urandom_range(0, 1));
         stop_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n)) : -1;
         do_move(n, dir, stop_at, 1'b0);
         model_move(n, stop_at);
         checks++; if (obs_timeout) begin errors++; $display("FAIL rand%0d_timeout n=%0d stop=%0d", t, n, stop_at); end
         checks++; if (obs_iv.size() != exp_iv.size()) begin errors++; $display("FAIL rand%0d_count got %0d want %0d (n=%0d stop=%0d)", t, obs_iv.size(), exp_iv.size(), n, stop_at); end
         for (int i = 0; i < obs_iv.size() && i < exp_iv.size(); i++) begin
            checks++; if (obs_iv[i] != exp_iv[i]) begin errors++; $display("FAIL rand%0d_interval[%0d] got %0d want %0d", t, i, obs_iv[i], exp_iv[i]); end
         end
         for (int i = 0; i < obs_ph.size(); i++) begin
            midx = next_idx(midx, dir);
            checks++; if (obs_ph[i] !== SEQ_TAB[midx]) begin errors++; $display("FAIL rand%0d_phase[%0d] got %b want %b", t, i, obs_ph[i], SEQ_TAB[midx]); end
         end
         checks++; if (obs_done_pulse !== 1'b1) begin errors++; $display("FAIL rand%0d_done_with_pulse got %b want 1", t, obs_done_pulse); end
      end
   endtask

   initial begin
      test_reset();
      test_fwd_ten();
      test_reset();
      test_rev_four();
      test_zero_steps();
      test_stop_cruise();
      test_reset_mid_move();
      test_reset();
      test_eight_steps();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
